computer_player: RTL and testbench

COMPUTER_PLAYER -- requirements
Module: computer_player

---
 rtl/computer_player.sv | 198 +++++++++++++++++++
 tb/tb_computer_player.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/computer_player.sv
// computer_player
//   Picks the computer's next tic-tac-toe move from a snapshot of the board.
//   It tries, in order:
//     1. a winning line (two COMPUTER pieces and one EMPTY cell),
//     2. a blocking line (two PLAYER pieces and one EMPTY cell),
//     3. the first EMPTY cell in the order 4,0,2,6,8,1,3,5,7.
//   Each phase examines one line or one cell per clock, so latency depends
//   on where the hit is found. If the board is full, a no_move strobe is
//   issued instead of a move.
//
// Ports
//   clk              rising-edge clock
//   rstn             asynchronous active-low reset
//   start            request one move (only sampled while idle)
//   game_over        board stage already flagged win/tie; blocks new requests
//   board[17:0]      cell i at bits [2i+1:2i], row-major cells 0-8
//   computer_move    one-cycle move strobe
//   computer_adderss cell index 0-8 of the issued move (held between moves)
//   busy             high whenever a request is in progress
//   no_move          one-cycle strobe: board had no empty cell
module computer_player #(
  parameter logic [1:0] EMPTY    = 2'b00,
  parameter logic [1:0] PLAYER   = 2'b01,
  parameter logic [1:0] COMPUTER = 2'b10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        game_over,
  input  logic [17:0] board,
  output logic        computer_move,
  output logic [3:0]  computer_adderss,
  output logic        busy,
  output logic        no_move
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SCAN_WIN   = 3'd1,
    SCAN_BLOCK = 3'd2,
    SCAN_PREF  = 3'd3,
    ISSUE      = 3'd4,
    NOMOVE     = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  idx_reg, idx_next;
  logic [17:0] snap_reg;
  logic [3:0]  addr_reg;
  logic        busy_reg, move_reg, nomove_reg;

  logic        snap_load;
  logic        capture;
  logic [3:0]  capture_cell;

  // Snapshot split into per-cell values so the scanners can index by cell.
  logic [1:0] cell_val [9];

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cells
      assign cell_val[gi] = snap_reg[2*gi+1:2*gi];
    end
  endgenerate

  // Cells of line k, packed {a, b, c}.
  function automatic logic [11:0] line_cells(input logic [2:0] k);
    case (k)
      3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
      3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
      3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
      3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
      3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
      3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
      3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
      default: line_cells = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  // Cell tested at preference position p.
  function automatic logic [3:0] pref_cell_of(input logic [3:0] p);
    case (p)
      4'd0:    pref_cell_of = 4'd4;
      4'd1:    pref_cell_of = 4'd0;
      4'd2:    pref_cell_of = 4'd2;
      4'd3:    pref_cell_of = 4'd6;
      4'd4:    pref_cell_of = 4'd8;
      4'd5:    pref_cell_of = 4'd1;
      4'd6:    pref_cell_of = 4'd3;
      4'd7:    pref_cell_of = 4'd5;
      default: pref_cell_of = 4'd7;
    endcase
  endfunction

  // Line evaluation for the current index. The target piece depends on
  // which line phase is active; 2'b11 never equals a target or EMPTY, so it
  // behaves as an occupied, non-matching cell.
  logic [11:0] line_sel;
  logic [3:0]  cell_a, cell_b, cell_c;
  logic [1:0]  val_a, val_b, val_c;
  logic [1:0]  target;
  logic [1:0]  n_target, n_empty;
  logic        line_hit;
  logic [3:0]  line_empty_cell;
  logic [3:0]  pref_cell;
  logic        pref_empty;

  always_comb begin
    line_sel = line_cells(idx_reg[2:0]);
    cell_a   = line_sel[11:8];
    cell_b   = line_sel[7:4];
    cell_c   = line_sel[3:0];
    val_a    = cell_val[cell_a];
    val_b    = cell_val[cell_b];
    val_c    = cell_val[cell_c];
    target   = (state_reg == SCAN_WIN) ? COMPUTER : PLAYER;
    n_target = {1'b0, val_a == target} + {1'b0, val_b == target}
             + {1'b0, val_c == target};
    n_empty  = {1'b0, val_a == EMPTY} + {1'b0, val_b == EMPTY}
             + {1'b0, val_c == EMPTY};
    line_hit = (n_target == 2'd2) && (n_empty == 2'd1);
    if (val_a == EMPTY)      line_empty_cell = cell_a;
    else if (val_b == EMPTY) line_empty_cell = cell_b;
    else                     line_empty_cell = cell_c;
    pref_cell  = pref_cell_of(idx_reg);
    pref_empty = (cell_val[pref_cell] == EMPTY);
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    snap_load    = 1'b0;
    capture      = 1'b0;
    capture_cell = line_empty_cell;
    case (state_reg)
      IDLE: begin
        if (start && !game_over) begin
          state_next = SCAN_WIN;
          idx_next   = 4'd0;
          snap_load  = 1'b1;
        end
      end
      SCAN_WIN, SCAN_BLOCK: begin
        if (line_hit) begin
          state_next = ISSUE;
          capture    = 1'b1;
        end else if (idx_reg == 4'd7) begin
          state_next = (state_reg == SCAN_WIN) ? SCAN_BLOCK : SCAN_PREF;
          idx_next   = 4'd0;
        end else begin
          idx_next = idx_reg + 4'd1;
        end
      end
      SCAN_PREF: begin
        capture_cell = pref_cell;
        if (pref_empty) begin
          state_next = ISSUE;
          capture    = 1'b1;
        end else if (idx_reg == 4'd8) begin
          state_next = NOMOVE;
        end else begin
          idx_next = idx_reg + 4'd1;
        end
      end
      ISSUE:   state_next = IDLE;
      NOMOVE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and busy are registered from the next state so that they line
  // up exactly with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      idx_reg    <= 4'd0;
      snap_reg   <= {9{EMPTY}};
      addr_reg   <= 4'd0;
      busy_reg   <= 1'b0;
      move_reg   <= 1'b0;
      nomove_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      if (snap_load) snap_reg <= board;
      if (capture)   addr_reg <= capture_cell;
      busy_reg   <= (state_next != IDLE);
      move_reg   <= (state_next == ISSUE);
      nomove_reg <= (state_next == NOMOVE);
    end
  end

  assign computer_move    = move_reg;
  assign computer_adderss = addr_reg;
  assign busy             = busy_reg;
  assign no_move          = nomove_reg;

endmodule

// File: tb/tb_computer_player.sv
module tb_computer_player;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        game_over;
  logic [17:0] board;
  logic        computer_move;
  logic [3:0]  computer_adderss;
  logic        busy;
  logic        no_move;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  held_addr;

  computer_player dut (
    .clk              (clk),
    .rstn             (rstn),
    .start            (start),
    .game_over        (game_over),
    .board            (board),
    .computer_move    (computer_move),
    .computer_adderss (computer_adderss),
    .busy             (busy),
    .no_move          (no_move)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] brd;
    logic        go;
    int          kind;   // 0 none, 1 move, 2 no_move
    int          addr;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] pack9(input logic [1:0] c0, c1, c2, c3, c4,
                                        c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  // Reference: win lines, then block lines, then preference order; the
  // returned latency is counted in cycles after the accepting edge.
  task automatic model(input logic [17:0] brd, output int kind,
                       output int addr, output int lat);
    int lines [8][3];
    int order [9];
    int v [9];
    bit done;
    lines = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
              '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    order = '{4, 0, 2, 6, 8, 1, 3, 5, 7};
    for (int i = 0; i < 9; i++) v[i] = int'(brd[2*i +: 2]);
    kind = 2; addr = 0; lat = 26; done = 0;
    for (int pass = 0; pass < 2; pass++) begin
      int tgt;
      tgt = (pass == 0) ? 2 : 1;
      for (int k = 0; k < 8; k++) begin
        int nt, ne, ec;
        nt = 0; ne = 0; ec = 0;
        for (int j = 2; j >= 0; j--) begin
          if (v[lines[k][j]] == tgt) nt++;
          if (v[lines[k][j]] == 0) begin ne++; ec = lines[k][j]; end
        end
        if (!done && nt == 2 && ne == 1) begin
          done = 1; kind = 1; addr = ec; lat = 2 + 8*pass + k;
        end
      end
    end
    for (int p = 0; p < 9; p++) begin
      if (!done && v[order[p]] == 0) begin
        done = 1; kind = 1; addr = order[p]; lat = 18 + p;
      end
    end
  endtask

  task automatic run_req(input string name, input logic [17:0] brd,
                         input logic go, input int restart_at,
                         input int reset_at, input int kind, input int addr,
                         input int lat);
    int mv_cnt, nm_cnt, both, mv_cyc, nm_cyc, mv_addr, busy_cnt, busy_last;
    int exp_busy;
    mv_cnt = 0; nm_cnt = 0; both = 0; mv_cyc = -1; nm_cyc = -1;
    mv_addr = -1; busy_cnt = 0; busy_last = 0;
    @(negedge clk);
    board = brd; game_over = go; start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (busy) begin busy_cnt++; busy_last = n; end
      if (computer_move) begin
        mv_cnt++;
        if (mv_cyc < 0) begin mv_cyc = n; mv_addr = int'(computer_adderss); end
      end
      if (no_move) begin
        nm_cnt++;
        if (nm_cyc < 0) nm_cyc = n;
      end
      if (computer_move && no_move) both++;
      // Scramble inputs after acceptance; the snapshot must shield the scan.
      start = (n == restart_at);
      board = 18'($urandom);
      game_over = 1'($urandom_range(0, 1));
      if (reset_at > 0 && n == reset_at) begin
        rstn = 1'b0;
        #1;
        chk({name, " busy after async reset"}, int'(busy), 0);
        chk({name, " addr after async reset"}, int'(computer_adderss), 0);
      end
      if (reset_at > 0 && n == reset_at + 1) rstn = 1'b1;
    end
    start = 1'b0; game_over = 1'b0;
    if (reset_at > 0) held_addr = 4'd0;
    else if (kind == 1) held_addr = 4'(addr);
    exp_busy = go ? 0 : ((reset_at > 0) ? reset_at : lat);
    $display("req %s: move_cnt=%0d move@%0d addr=%0d nomove_cnt=%0d nomove@%0d busy_cycles=%0d",
             name, mv_cnt, mv_cyc, mv_addr, nm_cnt, nm_cyc, busy_cnt);
    chk({name, " move count"}, mv_cnt, int'(kind == 1));
    chk({name, " no_move count"}, nm_cnt, int'(kind == 2));
    chk({name, " overlap"}, both, 0);
    if (kind == 1) begin
      chk({name, " move cycle"}, mv_cyc, lat);
      chk({name, " move addr"}, mv_addr, addr);
    end
    if (kind == 2) chk({name, " no_move cycle"}, nm_cyc, lat);
    chk({name, " busy cycles"}, busy_cnt, exp_busy);
    chk({name, " busy last"}, busy_last, exp_busy);
    chk({name, " addr hold"}, int'(computer_adderss), int'(held_addr));
  endtask

  vec_t tbl [7];

  initial begin
    rstn = 1'b0; start = 1'b0; game_over = 1'b0; board = '0;
    held_addr = 4'd0;
    tbl[0] = '{pack9(2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0), 1'b0, 1, 4, 18};
    tbl[1] = '{pack9(2'd2,2'd2,2'd0,2'd1,2'd1,2'd0,2'd0,2'd0,2'd0), 1'b0, 1, 2, 2};
    tbl[2] = '{pack9(2'd2,2'd0,2'd0,2'd1,2'd1,2'd0,2'd0,2'd0,2'd0), 1'b0, 1, 5, 11};
    tbl[3] = '{pack9(2'd2,2'd1,2'd2,2'd2,2'd1,2'd1,2'd1,2'd2,2'd2), 1'b0, 2, 0, 26};
    tbl[4] = '{pack9(2'd3,2'd3,2'd3,2'd3,2'd3,2'd3,2'd3,2'd0,2'd3), 1'b0, 1, 7, 26};
    tbl[5] = '{pack9(2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0), 1'b1, 0, 0, 0};
    tbl[6] = '{pack9(2'd1,2'd2,2'd0,2'd0,2'd2,2'd0,2'd1,2'd0,2'd0), 1'b0, 1, 7, 6};

    #1;
    chk("reset computer_move", int'(computer_move), 0);
    chk("reset addr", int'(computer_adderss), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset no_move", int'(no_move), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++)
      run_req($sformatf("vec%0d", i), tbl[i].brd, tbl[i].go, 0, 0,
              tbl[i].kind, tbl[i].addr, tbl[i].lat);

    // Second start during a scan is dropped.
    run_req("restart_mid_scan", tbl[0].brd, 1'b0, 3, 0, 1, 4, 18);
    // Reset mid-scan aborts, then a normal request follows.
    run_req("reset_mid_scan", tbl[0].brd, 1'b0, 0, 5, 0, 0, 0);
    run_req("after_reset", tbl[1].brd, 1'b0, 0, 0, 1, 2, 2);

    for (int r = 0; r < 40; r++) begin
      logic [1:0] c [9];
      logic [17:0] b;
      logic go;
      int kind, addr, lat;
      for (int j = 0; j < 9; j++) begin
        int x;
        x = int'($urandom_range(0, 19));
        c[j] = (x < 6) ? 2'd0 : (x < 12) ? 2'd2 : (x < 18) ? 2'd1 : 2'd3;
      end
      b = pack9(c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7], c[8]);
      go = ($urandom_range(0, 7) == 0);
      model(b, kind, addr, lat);
      if (go) kind = 0;
      run_req($sformatf("rand%0d", r), b, go, 0, 0, kind, addr, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
